seven_seg_frame_ctrl: RTL
=========================

Name: seven_seg_frame_ctrl

Overview:
Parametrised successor to the fixed 4-digit scanner/decoder pair. It drives N multiplexed hex digits on a seven-segment display and contains its own scan-tick divider, so no external divided clock is needed. It double-buffers the displayed value so digits never tear mid-frame, and supports per-digit blanking. It sits between arithmetic/datapath blocks and the board an/seg pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits; legal range 2..8.
DIVIDE_BY, 17, scan advances one digit every 2**DIVIDE_BY clock cycles; benches set 2.

Ports:
clock  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
value  input  4*N_DIGITS  hex digits; digit i = value[4i+3:4i].
load  input  1  one-cycle strobe that captures value.
digit_blank  input  N_DIGITS  1 = digit i kept dark during its slot.
an  output  N_DIGITS  anodes, active-low, one-hot-low or all ones.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
frame_done  output  1  one-cycle pulse at each frame wrap.
pending  output  1  a loaded value is waiting for the frame boundary.

Behaviour:
- Single clock domain; reset is synchronous and active-high and overrides all other inputs.
- Reset values: tick counter 0, digit index 0, display reg 0, shadow reg 0, pending 0, frame_done 0, an all ones, seg 7'b1111111.
- Tick: free-running DIVIDE_BY-bit counter. tick = 1 in the cycle the counter equals all ones, i.e. once every 2**DIVIDE_BY clocks.
- Digit index: width clog2(N_DIGITS). On tick it increments. On tick with index N_DIGITS-1 it wraps to 0; that cycle is the frame boundary.
- frame_done: registered; high for exactly one cycle, the cycle after the boundary tick.
- Load with no boundary in the same cycle: shadow <= value, pending <= 1. A repeated load before the boundary overwrites shadow; last write wins.
- Frame boundary with pending = 1 and no load: display <= shadow, pending <= 0.
- Load in the boundary cycle: display <= value directly (load wins), pending <= 0, and any older shadow is discarded.
- Boundary with pending = 0 and no load: display unchanged.
- Outputs are registered and reflect the current index with one cycle of latency.
  - an = ~(1 << index), or all ones if digit_blank[index] = 1.
  - seg = hex-decode(display digit[index]), or 7'b1111111 when blanked.
- Hex patterns, active-low {g..a}: 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110; remaining codes per the standard hex font.
- digit_blank is sampled live every cycle and is not double-buffered.
- Reset mid-frame: the next cycle restores all reset values; any pending value is lost. The first cycle after reset is released shows an = ~1, seg = 1000000.

Optional Feature:
SEVSEG_LZB_EN
- Defined: leading-zero blanking. Digit i (i > 0) is dark if it and all higher display digits are 0. Digit 0 is never blanked by this rule. It ORs with digit_blank.
- Undefined: all digits shown unless digit_blank is set; no extra logic.

Decomposition:
- Package sevseg_pkg:
  - SEG_BLANK = 7'b1111111.
  - 16-entry hex-to-segment constant array.
  - seg_t typedef (logic [6:0]).
- Sub-module scan_tick_gen (DIVIDE_BY parameter; ports clock, reset, tick) holds the divider counter. Decode and buffering stay in the top-level block.

Test Plan:
All scenarios use DIVIDE_BY = 2, N_DIGITS = 4, so one digit lasts 4 clocks and one frame lasts 16 clocks.
1. Reset, then release with value = 0 -> an steps 1110, 1101, 1011, 0111 every 4 clocks with seg = 1000000; frame_done pulses every 16 clocks.
2. load with value = 16'hA5F1 mid-frame -> pending = 1; display unchanged until the boundary; the next frame shows seg 1111001 (1), 0001110 (F), 0010010 (5), 0001000 (A) in digits 0..3; pending clears.
3. load 16'h1111, then load 16'h2222 before the boundary -> the next frame shows 2222 only.
4. load asserted in the boundary cycle with 16'h0008 -> display updates that cycle; pending stays 0; digit 0 shows 0000000.
5. digit_blank = 4'b0100 -> during slot 2 an = 1111 and seg = 1111111; other slots are normal.
6. Reset asserted mid-frame with pending = 1 -> the next cycle an = 1111 and pending = 0. With SEVSEG_LZB_EN defined and display 16'h0030, digits 3 and 2 are dark, digit 1 shows 3, digit 0 shows 0.

Source files
------------

// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared types and constants for the seven-segment frame controller.
//   seg_t      : segment vector {g,f,e,d,c,b,a}, active-low.
//   SEG_BLANK  : all segments dark.
//   HEX_SEG    : hex font, indexed by the 4-bit digit value.
//   hex_decode : helper that looks a digit up in HEX_SEG.
package sevseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic seg_t hex_decode(input logic [3:0] digit);
    return HEX_SEG[digit];
  endfunction

endpackage

// File: rtl/seven_seg_frame_ctrl_scan_tick_gen.sv
// scan_tick_gen: free-running divider that produces the digit scan tick.
//   clock : system clock
//   reset : synchronous, active-high
//   tick  : high for one cycle every 2**DIVIDE_BY clocks (counter all ones)
module scan_tick_gen #(
  parameter int DIVIDE_BY = 17
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  logic [DIVIDE_BY-1:0] cnt_q;
  logic [DIVIDE_BY-1:0] cnt_d;

  assign cnt_d = cnt_q + 1'b1;
  assign tick  = &cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seven_seg_frame_ctrl.sv
// seven_seg_frame_ctrl: N-digit multiplexed hex display driver with an
// internal scan divider, frame-synchronous double buffering and per-digit
// blanking.
//   clock       : system clock, the only clock
//   reset       : synchronous, active-high
//   value       : hex digits, digit i = value[4i+3:4i]
//   load        : one-cycle strobe capturing value
//   digit_blank : 1 = digit i dark during its slot (sampled live)
//   an          : anodes, active-low, one-hot-low or all ones
//   seg         : segments {g..a}, active-low
//   frame_done  : one-cycle pulse the cycle after each frame wrap
//   pending     : a loaded value is waiting for the frame boundary
// Build option: define SEVSEG_LZB_EN to enable leading-zero blanking.
module seven_seg_frame_ctrl
  import sevseg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DIVIDE_BY = 17
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   digit_blank,
  output logic [N_DIGITS-1:0]   an,
  output seg_t                  seg,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic                  tick;
  logic                  boundary;
  logic [IDX_W-1:0]      index_q,   index_d;
  logic [4*N_DIGITS-1:0] display_q, display_d;
  logic [4*N_DIGITS-1:0] shadow_q,  shadow_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q;
  logic [N_DIGITS-1:0]   an_q,      an_d;
  seg_t                  seg_q,     seg_d;
  logic [3:0]            cur_digit;
  logic                  blank;
  logic [N_DIGITS-1:0]   lzb;

  scan_tick_gen #(
    .DIVIDE_BY(DIVIDE_BY)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign boundary = tick && (index_q == LAST_IDX);

`ifdef SEVSEG_LZB_EN
  // Digit gi is a leading zero when it and every higher digit are zero.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lzb
    if (gi == 0) begin : g_d0
      assign lzb[gi] = 1'b0;
    end else begin : g_dn
      assign lzb[gi] = (display_q[4*N_DIGITS-1:4*gi] == '0);
    end
  end
`else
  assign lzb = '0;
`endif

  always_comb begin
    index_d   = index_q;
    display_d = display_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (tick) begin
      index_d = boundary ? '0 : index_q + 1'b1;
    end

    if (boundary) begin
      // A load landing on the boundary goes straight to the display and
      // supersedes whatever was waiting in the shadow.
      if (load) begin
        display_d = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        display_d = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    cur_digit = display_q[{index_q, 2'b00} +: 4];
    blank     = digit_blank[index_q] | lzb[index_q];
    an_d      = blank ? '1 : ~(N_DIGITS'(1) << index_q);
    seg_d     = blank ? SEG_BLANK : hex_decode(cur_digit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index_q      <= '0;
      display_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
    end else begin
      index_q      <= index_d;
      display_q    <= display_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= boundary;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule
